divider_param_module: RTL and testbench
=======================================

# divider_param_module

Parametrised iterative integer divider with a selectable signed/unsigned mode and a level start / pulse done handshake. It is the next generation of the fixed 8-bit signed divider family. Each request takes a fixed, data-independent latency of WIDTH+2 clocks, and a request may carry any operands. Divide-by-zero and signed overflow are reported through status flags. The block sits beside the control FSMs that sequence arithmetic jobs. The caller holds start_sig high until it sees done_sig, then drops start_sig.

## Interface
- WIDTH, 8: operand, quotient and remainder width in bits; legal range 2..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_sig  in  1  request level; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start_sig.
- dividend  in  WIDTH  numerator; sampled with start_sig.
- divisor  in  WIDTH  denominator; sampled with start_sig.
- done_sig  out  1  one-cycle pulse; results are valid from this cycle.
- quotient  out  WIDTH  result quotient; held until the next done_sig.
- reminder  out  WIDTH  result remainder; held until the next done_sig.
- div_by_zero  out  1  divisor was 0 for the last result; held.
- overflow  out  1  signed −2^(WIDTH−1) / −1 for the last result; held.

## Operation
- States: IDLE → PREP → ITER → FIX → DONE → IDLE.
- IDLE: start_sig=1 latches dividend, divisor and signed_mode, then goes to PREP. Otherwise the block stays in IDLE.
- PREP:
  - In signed mode, records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), and converts both operands to WIDTH-bit unsigned magnitudes. The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), which fits unsigned.
  - In unsigned mode, both sign bits are 0.
  - Clears the WIDTH+1-bit partial remainder and the iteration counter.
  - Evaluates the zero and overflow conditions.
- ITER: exactly WIDTH cycles of restoring division, MSB first. Each cycle shifts the next dividend bit into the partial remainder, trial-subtracts the divisor magnitude, keeps the result if it is non-negative, and shifts the quotient bit in. After the WIDTH-th cycle the block goes to FIX.
- FIX: negates the quotient if sign_q is set and the remainder if sign_r is set, then registers all outputs and asserts done_sig. Normal-case semantics: truncation toward zero, remainder takes the sign of the dividend, and dividend = quotient·divisor + reminder.
- Divide by zero (either mode): quotient = all ones, reminder = dividend as supplied, div_by_zero=1, overflow=0.
- Signed overflow: quotient = −2^(WIDTH−1) (wraps), reminder = 0, overflow=1.
- DONE: deasserts done_sig and returns to IDLE without checking start_sig. A start_sig still high in the cycle after done_sig therefore does not start a new job.
- A new job starts only when start_sig is high while the block is in IDLE. A caller that keeps start_sig high issues back-to-back jobs.
- Inputs that change after they are latched are ignored until the next IDLE.

## Timing
- Reset values: state IDLE, done_sig 0, quotient 0, reminder 0, div_by_zero 0, overflow 0, all internal registers 0.
- If start_sig is sampled at edge T0, done_sig is high during the cycle following edge T0+WIDTH+2. Latency is WIDTH+2 edges for every operand value, zero divisor included.
- done_sig is high for exactly one cycle per job.
- Minimum spacing between the start edges of two jobs is WIDTH+4 edges.
- Outputs change only on the done_sig edge.
- Asserting rst_n low mid-job aborts the job immediately, with no done_sig, and all outputs return to their reset values.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package divider_pkg: state encoding localparams (IDLE, PREP, ITER, FIX, DONE) and the WIDTH legality check.
- Sub-module div_restore_step: combinational single-bit restoring step. Inputs: partial remainder, next dividend bit, divisor magnitude. Outputs: next partial remainder, quotient bit. It is instantiated once and iterated by the FSM.
- The counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=8, signed: 13/2 → 6 r 1; 13/−2 → −6 (0xFA) r 1; −13/2 → −6 r −1 (0xFF); −13/−2 → 6 r −1. Each done_sig exactly 10 edges after start.
- WIDTH=8, signed: 9/6 → 1 r 3; 9/−6 → −1 r 3; −9/6 → −1 r −3; −9/−6 → 1 r −3.
- WIDTH=8, unsigned: 0xF3/0x02 → 0x79 r 1; 0xFF/0xFF → 1 r 0; 5/7 → 0 r 5.
- Divide by zero:
  - WIDTH=8, signed 0x85/0 → quotient 0xFF, reminder 0x85, div_by_zero=1, same latency.
  - The next job clears the flag.
- Signed overflow and WIDTH=16:
  - WIDTH=8, signed 0x80/0xFF → quotient 0x80, reminder 0, overflow=1.
  - WIDTH=16, unsigned 60000/7 → 8571 r 3, done at 18 edges.
- Handshake and reset:
  - start_sig held high across done_sig issues back-to-back jobs at a spacing of WIDTH+4 edges.
  - rst_n pulsed low mid-ITER → no done_sig, all outputs 0.
  - After reset, a new job completes correctly.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the parametrised iterative divider:
// FSM state encoding and the operand-width legality check.
package divider_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  localparam int unsigned DIV_MIN_WIDTH = 2;
  localparam int unsigned DIV_MAX_WIDTH = 32;

  // True when w is a supported operand width.
  function automatic bit div_width_legal(input int unsigned w);
    return (w >= DIV_MIN_WIDTH) && (w <= DIV_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude and keep the
// difference only when it does not go negative.
module div_restore_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] div_mag,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;

  // Trial subtraction; the compare is done on the full shifted value so no
  // remainder bit is lost, the kept result always fits WIDTH+1 bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, div_mag});
    rem_out = q_bit ? (shifted[WIDTH:0] - {1'b0, div_mag}) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/divider_param_module.sv
// Parametrised iterative integer divider, signed or unsigned per job.
// Fixed latency of WIDTH+2 clocks from the start_sig edge to done_sig.
// Handshake: start_sig is a level sampled only in IDLE together with the
// operands; done_sig is a one-cycle pulse and the result outputs are valid
// from that cycle and held until the next done_sig. The caller holds
// start_sig until it sees done_sig; a start_sig still high in the cycle
// after done_sig is ignored (DONE returns to IDLE without sampling it).
module divider_param_module
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] reminder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  if (!div_width_legal(WIDTH)) begin : g_width_check
    $error("divider_param_module: WIDTH must be in 2..32");
  end

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] raw_dvd_q, raw_dvd_d;   // dividend as supplied
  logic [WIDTH-1:0] dq_q, dq_d;             // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;           // divisor, becomes magnitude in PREP
  logic [WIDTH:0]   rem_q, rem_d;           // partial remainder
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dz_out_q, dz_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dq_q[WIDTH-1]),
    .div_mag (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state and datapath: latch, take magnitudes, iterate, fix signs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    raw_dvd_d = raw_dvd_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dz_out_d  = dz_out_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start_sig) begin
          raw_dvd_d = dividend;
          dq_d      = dividend;
          dvs_d     = divisor;
          mode_d    = signed_mode;
          state_d   = ST_PREP;
        end
      end
      ST_PREP: begin
        neg_quo_d = mode_q & (raw_dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        neg_rem_d = mode_q & raw_dvd_q[WIDTH-1];
        dq_d      = (mode_q && raw_dvd_q[WIDTH-1]) ? -raw_dvd_q : raw_dvd_q;
        dvs_d     = (mode_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
        rem_d     = '0;
        cnt_d     = '0;
        dz_d      = (dvs_q == '0);
        ovf_d     = mode_q && (raw_dvd_q == MOST_NEG) && (dvs_q == '1);
        state_d   = ST_ITER;
      end
      ST_ITER: begin
        rem_d = step_rem;
        dq_d  = {dq_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        done_d    = 1'b1;
        dz_out_d  = dz_q;
        ovf_out_d = ovf_q;
        if (dz_q) begin
          quo_out_d = '1;
          rem_out_d = raw_dvd_q;
        end else if (ovf_q) begin
          quo_out_d = MOST_NEG;
          rem_out_d = '0;
        end else begin
          quo_out_d = neg_quo_q ? -dq_q : dq_q;
          rem_out_d = WIDTH'(neg_rem_q ? -rem_q : rem_q);
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      raw_dvd_q <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_out_q  <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      raw_dvd_q <= raw_dvd_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dz_out_q  <= dz_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign done_sig    = done_q;
  assign quotient    = quo_out_q;
  assign reminder    = rem_out_q;
  assign div_by_zero = dz_out_q;
  assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_divider_param_module.sv
// Directed bench for divider_param_module at WIDTH=8 and WIDTH=16:
// a vector table of hand-computed results plus handshake/reset sequences.
module tb_divider_param_module;

  logic clk = 1'b0;
  logic rst_n;

  // clock / reset
  always #5 clk = ~clk;

  logic       start8, sm8, done8, dz8, ovf8;
  logic [7:0] dvd8, dvs8, q8, r8;
  logic        start16, sm16, done16, dz16, ovf16;
  logic [15:0] dvd16, dvs16, q16, r16;

  divider_param_module #(.WIDTH(8)) dut8 (
    .clk (clk), .rst_n (rst_n), .start_sig (start8), .signed_mode (sm8),
    .dividend (dvd8), .divisor (dvs8), .done_sig (done8), .quotient (q8),
    .reminder (r8), .div_by_zero (dz8), .overflow (ovf8)
  );

  divider_param_module #(.WIDTH(16)) dut16 (
    .clk (clk), .rst_n (rst_n), .start_sig (start16), .signed_mode (sm16),
    .dividend (dvd16), .divisor (dvs16), .done_sig (done16), .quotient (q16),
    .reminder (r16), .div_by_zero (dz16), .overflow (ovf16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        w16;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
  } vec_t;

  vec_t vecs[20];
  int   n_vecs;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // driver: one complete job on the selected instance, with all checks
  task automatic run_job(input vec_t v);
    int   edges;
    bit   seen;
    logic d;
    @(negedge clk);
    if (v.w16) begin
      sm16 = v.mode; dvd16 = v.a[15:0]; dvs16 = v.b[15:0]; start16 = 1'b1;
    end else begin
      sm8 = v.mode; dvd8 = v.a[7:0]; dvs8 = v.b[7:0]; start8 = 1'b1;
    end
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      d = v.w16 ? done16 : done8;
      if (d) seen = 1'b1;
    end
    start8  = 1'b0;
    start16 = 1'b0;
    check({v.name, " done_seen"}, 32'(seen), 32'd1);
    check({v.name, " latency"}, 32'(edges - 1), v.w16 ? 32'd18 : 32'd10);
    if (v.w16) begin
      check({v.name, " quotient"}, {16'b0, q16}, v.q);
      check({v.name, " reminder"}, {16'b0, r16}, v.r);
      check({v.name, " div_by_zero"}, 32'(dz16), 32'(v.dz));
      check({v.name, " overflow"}, 32'(ovf16), 32'(v.ovf));
    end else begin
      check({v.name, " quotient"}, {24'b0, q8}, v.q);
      check({v.name, " reminder"}, {24'b0, r8}, v.r);
      check({v.name, " div_by_zero"}, 32'(dz8), 32'(v.dz));
      check({v.name, " overflow"}, 32'(ovf8), 32'(v.ovf));
    end
    @(posedge clk);
    #1;
    d = v.w16 ? done16 : done8;
    check({v.name, " done_one_cycle"}, 32'(d), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " done8"}, 32'(done8), 32'd0);
    check({name, " q8"}, {24'b0, q8}, 32'd0);
    check({name, " r8"}, {24'b0, r8}, 32'd0);
    check({name, " dz8"}, 32'(dz8), 32'd0);
    check({name, " ovf8"}, 32'(ovf8), 32'd0);
  endtask

  task automatic add(input string name, input logic w16, input logic mode,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r,
                     input logic dz, input logic ovf);
    vecs[n_vecs] = '{name, w16, mode, a, b, q, r, dz, ovf};
    n_vecs++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int first;
    int second;
    int pulses;

    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; dvd8 = '0; dvs8 = '0;
    start16 = 1'b0; sm16 = 1'b0; dvd16 = '0; dvs16 = '0;

    n_vecs = 0;
    //   name          w16  sgn  a         b         q         r         dz ovf
    add("s 13/2",      0,   1,   32'h0D,   32'h02,   32'h06,   32'h01,   0, 0);
    add("s 13/-2",     0,   1,   32'h0D,   32'hFE,   32'hFA,   32'h01,   0, 0);
    add("s -13/2",     0,   1,   32'hF3,   32'h02,   32'hFA,   32'hFF,   0, 0);
    add("s -13/-2",    0,   1,   32'hF3,   32'hFE,   32'h06,   32'hFF,   0, 0);
    add("s 9/6",       0,   1,   32'h09,   32'h06,   32'h01,   32'h03,   0, 0);
    add("s 9/-6",      0,   1,   32'h09,   32'hFA,   32'hFF,   32'h03,   0, 0);
    add("s -9/6",      0,   1,   32'hF7,   32'h06,   32'hFF,   32'hFD,   0, 0);
    add("s -9/-6",     0,   1,   32'hF7,   32'hFA,   32'h01,   32'hFD,   0, 0);
    add("u F3/02",     0,   0,   32'hF3,   32'h02,   32'h79,   32'h01,   0, 0);
    add("u FF/FF",     0,   0,   32'hFF,   32'hFF,   32'h01,   32'h00,   0, 0);
    add("u 5/7",       0,   0,   32'h05,   32'h07,   32'h00,   32'h05,   0, 0);
    add("u 80/FF",     0,   0,   32'h80,   32'hFF,   32'h00,   32'h80,   0, 0);
    add("s 85/0",      0,   1,   32'h85,   32'h00,   32'hFF,   32'h85,   1, 0);
    add("s clr_dz",    0,   1,   32'h0D,   32'h02,   32'h06,   32'h01,   0, 0);
    add("u 07/0",      0,   0,   32'h07,   32'h00,   32'hFF,   32'h07,   1, 0);
    add("s 80/FF ovf", 0,   1,   32'h80,   32'hFF,   32'h80,   32'h00,   0, 1);
    add("w16 u 60000/7", 1, 0,   32'hEA60, 32'h0007, 32'h217B, 32'h0003, 0, 0);
    add("w16 s -30000/7",1, 1,   32'h8AD0, 32'h0007, 32'hEF43, 32'hFFFB, 0, 0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset q16", {16'b0, q16}, 32'd0);
    check("reset done16", 32'(done16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back jobs with start held high: 100/7 = 14 r 2
    @(negedge clk);
    sm8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7; start8 = 1'b1;
    edges = 0; first = 0; second = 0;
    while (second == 0 && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (done8) begin
        if (first == 0) first = edges;
        else second = edges;
      end
    end
    start8 = 1'b0;
    check("b2b first_latency", 32'(first - 1), 32'd10);
    check("b2b spacing", 32'(second - first), 32'd12);
    check("b2b quotient", {24'b0, q8}, 32'd14);
    check("b2b reminder", {24'b0, r8}, 32'd2);
    pulses = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (done8) pulses++;
    end
    check("b2b no_third_job", 32'(pulses), 32'd0);

    // vector table
    for (int i = 0; i < n_vecs; i++) begin
      run_job(vecs[i]);
    end

    // reset mid-ITER after the overflow result is on the outputs
    @(negedge clk);
    sm8 = 1'b1; dvd8 = 8'h85; dvs8 = 8'h03; start8 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_outputs_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done8) pulses++;
    end
    check("abort no_done", 32'(pulses), 32'd0);
    check_outputs_zero("after_abort");

    // a fresh job after reset: -123/3 = -41 r 0
    run_job('{"post_reset s -123/3", 1'b0, 1'b1, 32'h85, 32'h03, 32'hD7, 32'h00, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
